// File: rtl/aline_capture_buffer.sv
// Ping-pong A-line capture buffer: one bank captures a sweep of ADC samples
// while the other bank streams a finished A-line out over a valid/ready port.
module aline_capture_buffer #(
  parameter int NSAMPLES = 1024,
  parameter int DATA_W   = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              sweep_trig,
  input  logic [DATA_W-1:0] adc_data,
  input  logic [10:0]       sample_addr,
  output logic              cnt_sclr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              overflow,
  output logic [15:0]       drop_count
);

  localparam int          AW     = (NSAMPLES > 1) ? $clog2(NSAMPLES) : 1;
  localparam logic [11:0] N_SIZE = 12'(NSAMPLES);
  localparam logic [11:0] N_LAST = 12'(NSAMPLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_CAPTURE} wr_state_t;

  wr_state_t         state;
  logic [DATA_W-1:0] bank0 [NSAMPLES];
  logic [DATA_W-1:0] bank1 [NSAMPLES];
  logic [1:0]        full;
  logic [1:0]        full_next;
  logic              wr_bank;
  logic              rd_bank;
  logic              trig_q;
  logic              trig_armed;
  logic              rd_active;
  logic [11:0]       rd_ptr;
  logic [DATA_W-1:0] rd_word;

  // The armed flag keeps a trigger that is already high at reset release from
  // looking like a fresh edge.
  logic trig_edge;
  assign trig_edge = trig_armed && sweep_trig && !trig_q;

  logic [11:0] addr_ext;
  logic        cap_write;
  logic        cap_done;
  assign addr_ext  = {1'b0, sample_addr};
  assign cap_write = (state == ST_CAPTURE) && (addr_ext < N_SIZE);
  assign cap_done  = cap_write && (addr_ext == N_LAST);

  logic advance;
  logic rd_start;
  logic fetch;
  logic rd_done;
  assign advance  = !out_valid || out_ready;
  assign rd_start = !rd_active && full[rd_bank];
  assign fetch    = (rd_start || rd_active) && advance && (rd_ptr < N_SIZE);
  assign rd_done  = out_valid && out_ready && out_last;

  // A bank released by the reader on this very edge is already usable.
  logic wr_bank_free;
  assign wr_bank_free = !full[wr_bank] || (rd_done && (rd_bank == wr_bank));

  // NOTE: every variable driven in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    full_next = full;
    if (rd_done)  full_next[rd_bank] = 1'b0;
    if (cap_done) full_next[wr_bank] = 1'b1;
  end

  // NOTE: sample storage has no reset; contents are only meaningful once a bank is FULL.
  always_ff @(posedge clock) begin
    if (cap_write) begin
      if (wr_bank) bank1[sample_addr[AW-1:0]] <= adc_data;
      else         bank0[sample_addr[AW-1:0]] <= adc_data;
    end
  end

  assign rd_word = rd_bank ? bank1[rd_ptr[AW-1:0]] : bank0[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      full       <= 2'b00;
      wr_bank    <= 1'b0;
      trig_q     <= 1'b0;
      trig_armed <= 1'b0;
      cnt_sclr   <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= 16'h0000;
    end else begin
      trig_q     <= sweep_trig;
      trig_armed <= 1'b1;
      full       <= full_next;
      overflow   <= 1'b0;
      cnt_sclr   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (trig_edge) begin
            if (wr_bank_free) begin
              state    <= ST_CLEAR;
              cnt_sclr <= 1'b1;
            end else begin
              overflow <= 1'b1;
              if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end
          end
        end
        ST_CLEAR: state <= ST_CAPTURE;
        ST_CAPTURE: begin
          if (cap_done) begin
            wr_bank <= ~wr_bank;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read pipeline: the output register is refilled whenever it is empty or
  // being accepted, which gives one word per cycle under continuous ready.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_bank   <= 1'b0;
      rd_active <= 1'b0;
      rd_ptr    <= 12'd0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (rd_start) rd_active <= 1'b1;
      if (fetch) begin
        out_data  <= rd_word;
        out_valid <= 1'b1;
        out_last  <= (rd_ptr == N_LAST);
        rd_ptr    <= rd_ptr + 12'd1;
      end else if (advance) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      if (rd_done) begin
        rd_active <= 1'b0;
        rd_ptr    <= 12'd0;
        rd_bank   <= ~rd_bank;
      end
    end
  end

endmodule
